edac_encoder: RTL and testbench
===============================

Name: edac_encoder

Overview:
- Transmit-side counterpart of the EDAC decoder. Takes an 8-bit payload and an 8-bit CRC polynomial, and computes the CRC remainder bit-serially, one division step per clock.
- Places the data and CRC bits into a 21-bit Hamming(21,16) codeword and registers the 32-bit result behind a valid/ready handshake.
- Sits in front of protected storage or links whose reads go through the EDAC decoder.
- Has an optional single-bit fault-injection path so the decoder's correction logic can be exercised.

Parameters:
- CRC_STEPS, 8, number of division steps. Fixed to 8; not to be overridden.
- ZERO_PAD, 11'h000, value driven on codeword bits [31:21].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  payload offered
- in_ready  out  1  encoder can accept
- din  in  8  payload data
- crc_poly  in  8  CRC polynomial, sampled at acceptance
- err_inject  in  5  0 = no injection; N in 1..21 flips codeword bit N-1; values 22..31 are ignored. Sampled at acceptance.
- out_valid  out  1  codeword available
- out_ready  in  1  downstream accepts the codeword
- dout  out  32  encoded codeword
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, CRC, HOLD.
- Reset (synchronous): state=IDLE, in_ready=1, out_valid=0, dout=0, busy=0, step counter=0. rst overrides everything, including mid-CRC and HOLD; any in-flight word is discarded.
- in_ready = (state==IDLE). Acceptance occurs on an edge where in_valid && in_ready.
- On the acceptance edge:
  - work = {din, 8'h00}
  - pl = crc_poly << 8
  - din, crc_poly and err_inject are latched
  - cnt = 0, state → CRC
- CRC state, one step per edge, with k = 15 - cnt:
  - if work[k]==1, work ^= pl
  - then pl >>= 1 and cnt++
  - On the edge with cnt==7, the step completes, the codeword is built and registered into dout, out_valid → 1, and state → HOLD.
  - out_valid therefore rises after the 8th edge following acceptance.
- crc = work[7:0] after the 8 steps. The algorithm is applied unchanged even when crc_poly[7]==0 (must be bit-exact with the decoder check). crc[0] is always 0 by construction.
- Codeword map (index = dout bit):
  - crc[0..7] → 2, 4, 5, 6, 8, 9, 10, 11
  - data[0..7] → 12, 13, 14, 16, 17, 18, 19, 20
- Parity bits, even parity so that the decoder's syndrome is 0:
  - p at index 0 = XOR of indices 2, 4, …, 20 (even indices)
  - p at index 1 = XOR of 2, 5, 6, 9, 10, 13, 14, 17, 18
  - p at index 3 = XOR of 4, 5, 6, 11, 12, 13, 14, 19, 20
  - p at index 7 = XOR of 8..14
  - p at index 15 = XOR of 16..20
- dout[31:21] = ZERO_PAD.
- Injection is applied after parity is computed: if the latched err_inject is in 1..21, flip dout[err_inject-1]; otherwise no change.
- HOLD state: dout and out_valid are held stable while out_ready=0. On an edge with out_ready=1: out_valid → 0, state → IDLE. dout retains its last value.
- Back-to-back operation: in_ready is low during CRC and HOLD, so there is no overlap. Minimum issue interval is 10 cycles (1 IDLE + 8 CRC + 1 HOLD with out_ready=1).
- in_valid asserted while busy is ignored (no latch). Changes on din, crc_poly or err_inject after acceptance have no effect on the word in flight.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Reset, then din=8'h01, crc_poly=8'hD5, err_inject=0, out_ready=1 → crc=8'hAA; out_valid high 8 edges after acceptance; dout=32'h00001AD1; feeding this word to the decoder gives valid=1, Dout=8'h01.
- Same as the previous case with err_inject=5 → dout=32'h00001AC1; the decoder corrects it: valid=1, Dout=8'h01.
- din=8'h00 with any crc_poly, err_inject=0 → dout=32'h00000000 after 8 steps.
- Backpressure: out_ready=0 for 20 cycles after out_valid rises → dout and out_valid stable, in_ready=0, and a new in_valid pulse is ignored. Then out_ready=1 → one-cycle handshake, IDLE, in_ready=1.
- Reset mid-CRC: assert rst on the 4th CRC edge → next cycle state=IDLE, out_valid=0, dout=0, in_ready=1, and no codeword is emitted.
- Random sweep: 1000 words with random din, random crc_poly with bit7=1, and err_inject in 0..21 → the decoder returns valid=1 and Dout=din for every word; in_valid/out_ready are randomized and no word is lost or duplicated.

Source files
------------

// File: rtl/edac_encoder.sv
// edac_encoder: bit-serial CRC (one division step per clock) feeding a Hamming(21,16)
// codeword, registered behind a valid/ready handshake with optional single-bit fault injection.
`default_nettype none

module edac_encoder #(
  parameter int         CRC_STEPS = 8,
  parameter logic [10:0] ZERO_PAD  = 11'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  din,
  input  logic [7:0]  crc_poly,
  input  logic [4:0]  err_inject,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CRC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] LAST_STEP = 3'(CRC_STEPS - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] work_q, work_d;
  logic [15:0] pl_q, pl_d;
  logic [7:0]  data_q, data_d;
  logic [4:0]  inj_q, inj_d;
  logic [31:0] dout_q, dout_d;
  logic        out_valid_q, out_valid_d;

  logic [3:0]  step_bit;
  logic [15:0] work_step;

  function automatic logic [31:0] build_codeword(input logic [7:0] d,
                                                 input logic [7:0] c,
                                                 input logic [4:0] inj);
    logic [20:0] cw;
    cw     = '0;
    cw[2]  = c[0];
    cw[4]  = c[1];
    cw[5]  = c[2];
    cw[6]  = c[3];
    cw[8]  = c[4];
    cw[9]  = c[5];
    cw[10] = c[6];
    cw[11] = c[7];
    cw[12] = d[0];
    cw[13] = d[1];
    cw[14] = d[2];
    cw[16] = d[3];
    cw[17] = d[4];
    cw[18] = d[5];
    cw[19] = d[6];
    cw[20] = d[7];
    cw[0]  = ^{cw[2], cw[4], cw[6], cw[8], cw[10], cw[12], cw[14], cw[16], cw[18], cw[20]};
    cw[1]  = ^{cw[2], cw[5], cw[6], cw[9], cw[10], cw[13], cw[14], cw[17], cw[18]};
    cw[3]  = ^{cw[4], cw[5], cw[6], cw[11], cw[12], cw[13], cw[14], cw[19], cw[20]};
    cw[7]  = ^cw[14:8];
    cw[15] = ^cw[20:16];
    // Fault injection goes in after parity so the decoder sees a genuine single-bit error.
    if (inj >= 5'd1 && inj <= 5'd21) begin
      cw = cw ^ (21'd1 << (inj - 5'd1));
    end
    return {ZERO_PAD, cw};
  endfunction

  assign step_bit  = 4'd15 - {1'b0, cnt_q};
  assign work_step = work_q[step_bit] ? (work_q ^ pl_q) : work_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    pl_d        = pl_q;
    data_d      = data_q;
    inj_d       = inj_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = {din, 8'h00};
          pl_d    = {crc_poly, 8'h00};
          data_d  = din;
          inj_d   = err_inject;
          cnt_d   = 3'd0;
          state_d = S_CRC;
        end
      end
      S_CRC: begin
        work_d = work_step;
        pl_d   = pl_q >> 1;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == LAST_STEP) begin
          dout_d      = build_codeword(data_q, work_step[7:0], inj_q);
          out_valid_d = 1'b1;
          cnt_d       = 3'd0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      work_q      <= 16'h0000;
      pl_q        <= 16'h0000;
      data_q      <= 8'h00;
      inj_q       <= 5'd0;
      dout_q      <= 32'h0000_0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      pl_q        <= pl_d;
      data_q      <= data_d;
      inj_q       <= inj_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_edac_encoder.sv
// tb_edac_encoder: scoreboard bench; stimulus pushes expectations, a monitor pops on each
// output handshake and checks exact words or decodes them with an independent decoder model.
`default_nettype none

module tb_edac_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  din;
  logic [7:0]  crc_poly;
  logic [4:0]  err_inject;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  din;
    logic [7:0]  poly;
    logic [4:0]  err;
    logic        exact;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  logic sweep_done;

  edac_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .crc_poly   (crc_poly),
    .err_inject (err_inject),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Remainder of din*x^7 modulo poly, shifted up one place.
  function automatic logic [7:0] model_crc(input logic [7:0] d, input logic [7:0] poly);
    logic [14:0] r;
    r = {d, 7'b0};
    for (int i = 14; i >= 7; i--) begin
      if (r[i]) r = r ^ (15'(poly) << (i - 7));
    end
    return {r[6:0], 1'b0};
  endfunction

  exp_t        m_e;
  logic [20:0] m_cw;
  logic [4:0]  m_syn;
  logic [7:0]  m_data;
  logic [7:0]  m_crc;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got dout=%h, required no output", dout);
      end else begin
        m_e = sb.pop_front();
        if (m_e.exact) begin
          chk("dout_exact", dout, m_e.word);
        end else begin
          m_cw  = dout[20:0];
          m_syn = 5'd0;
          for (int i = 0; i < 21; i++) begin
            if (m_cw[i]) m_syn = m_syn ^ 5'(i + 1);
          end
          if (m_syn >= 5'd1 && m_syn <= 5'd21) m_cw[m_syn - 5'd1] = ~m_cw[m_syn - 5'd1];
          m_data = {m_cw[20], m_cw[19], m_cw[18], m_cw[17], m_cw[16], m_cw[14], m_cw[13], m_cw[12]};
          m_crc  = {m_cw[11], m_cw[10], m_cw[9], m_cw[8], m_cw[6], m_cw[5], m_cw[4], m_cw[2]};
          chk("syndrome", 32'(m_syn), 32'(m_e.err));
          chk("decoded_data", 32'(m_data), 32'(m_e.din));
          chk("decoded_crc", 32'(m_crc), 32'(model_crc(m_data, m_e.poly)));
          chk("zero_pad", 32'(dout[31:21]), 32'd0);
        end
      end
    end
  end

  // Offer one word; returns at accept-edge + 1 with in_valid dropped.
  task automatic send(input logic [7:0] d, input logic [7:0] p, input logic [4:0] e,
                      input logic push, input logic ex, input logic [31:0] w);
    logic acc;
    int   n;
    exp_t x;
    in_valid   = 1'b1;
    din        = d;
    crc_poly   = p;
    err_inject = e;
    n          = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
    end else if (push) begin
      x.din   = d;
      x.poly  = p;
      x.err   = e;
      x.exact = ex;
      x.word  = w;
      sb.push_back(x);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int   lat;
    logic stable;
    rst        = 1'b1;
    in_valid   = 1'b0;
    din        = 8'h00;
    crc_poly   = 8'h00;
    err_inject = 5'd0;
    out_ready  = 1'b1;
    sweep_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_dout", dout, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reference word, latency measured from the acceptance edge.
    send(8'h01, 8'hD5, 5'd0, 1'b1, 1'b1, 32'h0000_1AD1);
    wait_valid(lat);
    chk("latency", 32'(lat), 32'd8);
    @(posedge clk);
    #1;
    send(8'h01, 8'hD5, 5'd5, 1'b1, 1'b1, 32'h0000_1AC1);
    wait_valid(lat);
    @(posedge clk);
    #1;
    send(8'h00, 8'hB7, 5'd0, 1'b1, 1'b1, 32'h0000_0000);
    wait_valid(lat);
    @(posedge clk);
    #1;
    send(8'h00, 8'h3C, 5'd21, 1'b1, 1'b1, 32'h0010_0000);
    wait_valid(lat);
    @(posedge clk);
    #1;
    send(8'h00, 8'hD5, 5'd22, 1'b1, 1'b1, 32'h0000_0000);
    wait_valid(lat);
    @(posedge clk);
    #1;

    // Backpressure with an ignored in_valid pulse.
    out_ready = 1'b0;
    send(8'h01, 8'hD5, 5'd0, 1'b1, 1'b1, 32'h0000_1AD1);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd8);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c == 5);
      din      = 8'hFF;
      @(posedge clk);
      #1;
      if (dout !== 32'h0000_1AD1 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;

    // Reset on the 4th CRC edge discards the word.
    send(8'hA5, 8'hD5, 5'd0, 1'b0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_dout", dout, 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("rst_mid_no_emit", 32'(out_valid), 32'd0);

    // Random sweep with randomized in_valid gaps and out_ready.
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom), 8'($urandom) | 8'h80, 5'($urandom_range(0, 21)),
               1'b1, 1'b0, 32'd0);
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join

    for (int c = 0; c < 100 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
